// File: rtl/ram_raster_reader.sv
// Streams a width x height pixel frame from a synchronous-address RAM into a small output FIFO.
// Define RRD_ROW_STRIDE_EN to add a per-row address stride input; the default is a contiguous frame.
module ram_raster_reader #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CK,
  input  logic        RST_N,
  input  logic        start,
  input  logic [19:0] base_addr,
  input  logic [10:0] width,
  input  logic [9:0]  height,
`ifdef RRD_ROW_STRIDE_EN
  input  logic [19:0] stride,
`endif
  output logic [19:0] RAM_A,
  output logic        RAM_WE,
  output logic        RAM_OE,
  output logic [15:0] RAM_D,
  input  logic [15:0] RAM_Q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_eol,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [19:0] AddrMax = 20'd786431;
  localparam logic [20:0] AddrSpan = 21'd786432;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  state_e r_state, w_state_d;

  logic [10:0]   r_width, r_col;
  logic [19:0]   r_total, r_issued, r_addr, r_ram_a;
  logic          r_rd_vld, r_rd_eol, r_rd_last;
  logic [15:0]   r_mem_data [FIFO_DEPTH];
  logic          r_mem_eol  [FIFO_DEPTH];
  logic          r_mem_last [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;

  logic          w_issue, w_eol_i, w_last_i, w_push, w_pop, w_valid;
  logic [19:0]   w_addr_inc, w_addr_next;

  assign w_valid    = (r_count != '0);
  assign w_push     = r_rd_vld;
  assign w_pop      = w_valid && out_ready;
  // Occupancy counts the read sitting on RAM_A so its data always has a free slot.
  assign w_issue    = (r_state == StRun) &&
                      ((int'(r_count) + int'(r_rd_vld)) < int'(FIFO_DEPTH));
  assign w_eol_i    = (r_col == r_width - 11'd1);
  assign w_last_i   = (r_issued == r_total - 20'd1);
  assign w_addr_inc = (r_addr == AddrMax) ? 20'd0 : r_addr + 20'd1;

`ifdef RRD_ROW_STRIDE_EN
  logic [19:0] r_stride, r_row_start, w_row_next;
  logic [20:0] w_row_sum;
  // r_stride is pre-reduced below AddrSpan, so one conditional subtract suffices.
  assign w_row_sum   = {1'b0, r_row_start} + {1'b0, r_stride};
  assign w_row_next  = (w_row_sum >= AddrSpan) ? 20'(w_row_sum - AddrSpan) : w_row_sum[19:0];
  assign w_addr_next = w_eol_i ? w_row_next : w_addr_inc;
`else
  assign w_addr_next = w_addr_inc;
`endif

  always_ff @(posedge CK) begin
    if (!RST_N) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = (width != '0 && height != '0) ? StRun : StDone;
      StRun:   if (w_issue && w_last_i) w_state_d = StDrain;
      StDrain: if (!w_valid && !r_rd_vld) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    RAM_OE = (r_state == StRun) || (r_state == StDrain);
    busy   = RAM_OE;
    done   = (r_state == StDone);
  end

  always_ff @(posedge CK) begin
    if (!RST_N) begin
      r_width   <= '0;
      r_col     <= '0;
      r_total   <= '0;
      r_issued  <= '0;
      r_addr    <= '0;
      r_ram_a   <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_eol  <= 1'b0;
      r_rd_last <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
`ifdef RRD_ROW_STRIDE_EN
      r_stride    <= '0;
      r_row_start <= '0;
`endif
    end else begin
      if (r_state == StIdle && start) begin
        r_width  <= width;
        r_total  <= 20'(width) * 20'(height);
        r_col    <= '0;
        r_issued <= '0;
        r_addr   <= base_addr;
`ifdef RRD_ROW_STRIDE_EN
        r_stride    <= (stride > AddrMax) ? 20'(stride - AddrSpan[19:0]) : stride;
        r_row_start <= base_addr;
`endif
      end
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_ram_a   <= r_addr;
        r_rd_eol  <= w_eol_i;
        r_rd_last <= w_last_i;
        r_addr    <= w_addr_next;
        r_col     <= w_eol_i ? 11'd0 : r_col + 11'd1;
        r_issued  <= r_issued + 20'd1;
`ifdef RRD_ROW_STRIDE_EN
        if (w_eol_i) r_row_start <= w_row_next;
`endif
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= RAM_Q;
      r_mem_eol[r_wr_ptr]  <= r_rd_eol;
      r_mem_last[r_wr_ptr] <= r_rd_last;
    end
  end

  assign RAM_A     = r_ram_a;
  assign RAM_WE    = 1'b0;
  assign RAM_D     = 16'd0;
  assign out_valid = w_valid;
  assign out_data  = w_valid ? r_mem_data[r_rd_ptr] : 16'd0;
  assign out_eol   = w_valid && r_mem_eol[r_rd_ptr];
  assign out_last  = w_valid && r_mem_last[r_rd_ptr];

endmodule
